// File: rtl/common.sv
// Shared types and constants for the pipeline controller.
//   pc_sel_t      : next-PC source select driven on pc_sel_o.
//   pctrl_state_t : controller FSM state (normal flow / mul-div occupancy).
//   S_*           : bit index of each inter-stage register in en_o/flush_o.
package common;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_EXC = 2'd2
  } pc_sel_t;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } pctrl_state_t;

  localparam int unsigned S_F2D = 0;
  localparam int unsigned S_D2E = 1;
  localparam int unsigned S_E2M = 2;
  localparam int unsigned S_M2W = 3;

endpackage

// File: rtl/md_timer.sv
// Mul/div occupancy timer: a down-counter with load, decrement and hold.
//   clk_i, reset_i : clock, synchronous active-high reset (counter -> 0)
//   load_i         : load MD_LAT-2 (the launch cycle and the done cycle are
//                    not counted by the register itself)
//   dec_i          : decrement by one, saturating at zero
//   zero_o         : counter equals zero
module md_timer #(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned W      = $clog2(MD_LAT)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam logic [W-1:0] LOAD_VAL = W'(MD_LAT - 2);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: load has precedence, otherwise decrement or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage in-order core.
// Drives en/flush of the F2D, D2E, E2M, M2W registers plus PC enable/select,
// resolving hazards by fixed priority (exception > dmiss > mul/div > branch >
// load-use > imiss). Mul/div ops hold E for MD_LAT cycles via md_timer.
// Counts cycles with pc_en_o low outside reset in stall_cnt_o.
//   inputs : clk_i, reset_i, imiss_i, load_use_i, md_start_i,
//            branch_mispred_i, dmiss_i, exc_valid_i
//   outputs: pc_en_o, pc_sel_o[1:0], en_o[3:0], flush_o[3:0], md_done_o,
//            stall_cnt_o[CNT_W-1:0]
module pipe_ctrl
  import common::*;
#(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             imiss_i,
  input  logic             load_use_i,
  input  logic             md_start_i,
  input  logic             branch_mispred_i,
  input  logic             dmiss_i,
  input  logic             exc_valid_i,
  output logic             pc_en_o,
  output logic [1:0]       pc_sel_o,
  output logic [3:0]       en_o,
  output logic [3:0]       flush_o,
  output logic             md_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  pctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic    pc_en_s;
  pc_sel_t pc_sel_s;
  logic [3:0] en_s;
  logic [3:0] flush_s;
  logic    md_done_s;
  logic    md_load_s;
  logic    md_dec_s;
  logic    md_zero_s;

  md_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (md_load_s),
    .dec_i   (md_dec_s),
    .zero_o  (md_zero_s)
  );

  // priority mux: next state and all pipeline control outputs
  always_comb begin
    state_d   = state_q;
    pc_en_s   = 1'b1;
    pc_sel_s  = PC_SEQ;
    en_s      = 4'b1111;
    flush_s   = 4'b0000;
    md_done_s = 1'b0;
    md_load_s = 1'b0;
    md_dec_s  = 1'b0;

    if (reset_i) begin
      pc_en_s = 1'b0;
      en_s    = 4'b0000;
      flush_s = 4'b1111;
      state_d = RUN;
    end else if (exc_valid_i) begin
      // exception squashes everything, including an op in flight
      flush_s  = 4'b1111;
      pc_sel_s = PC_EXC;
      state_d  = RUN;
    end else if (dmiss_i) begin
      // stall at M; the mul/div timer holds because md_dec_s stays 0
      pc_en_s = 1'b0;
      en_s    = 4'b1000;
      flush_s = 4'b1000;
    end else if ((state_q == MD_WAIT) && !md_zero_s) begin
      pc_en_s  = 1'b0;
      en_s     = 4'b1100;
      flush_s  = 4'b0100;
      md_dec_s = 1'b1;
    end else if ((state_q == RUN) && md_start_i) begin
      // launch cycle counts as the first occupied E cycle
      pc_en_s   = 1'b0;
      en_s      = 4'b1100;
      flush_s   = 4'b0100;
      md_load_s = 1'b1;
      state_d   = MD_WAIT;
    end else begin
      // E is free (or releasing): md_start is not looked at in the done cycle
      if (state_q == MD_WAIT) begin
        md_done_s = 1'b1;
        state_d   = RUN;
      end else begin
        state_d = state_q;
      end
      if (branch_mispred_i) begin
        pc_sel_s = PC_BR;
        flush_s  = 4'b0011;
      end else if (load_use_i) begin
        pc_en_s = 1'b0;
        en_s    = 4'b1110;
        flush_s = 4'b0010;
      end else if (imiss_i) begin
        pc_en_s = 1'b0;
        flush_s = 4'b0001;
      end else begin
        pc_en_s = 1'b1;
      end
    end
  end

  // stall counter next value, wraps naturally at 2^CNT_W
  always_comb begin
    if (!pc_en_s) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // state and stall counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en_o     = pc_en_s;
  assign pc_sel_o    = pc_sel_s;
  assign en_o        = en_s;
  assign flush_o     = flush_s;
  assign md_done_o   = md_done_s;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level reference model of the hazard priorities.
module tb_pipe_ctrl;

  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 8;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             imiss_i = 1'b0;
  logic             load_use_i = 1'b0;
  logic             md_start_i = 1'b0;
  logic             branch_mispred_i = 1'b0;
  logic             dmiss_i = 1'b0;
  logic             exc_valid_i = 1'b0;
  logic             pc_en_o;
  logic [1:0]       pc_sel_o;
  logic [3:0]       en_o;
  logic [3:0]       flush_o;
  logic             md_done_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_ctrl #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .imiss_i          (imiss_i),
    .load_use_i       (load_use_i),
    .md_start_i       (md_start_i),
    .branch_mispred_i (branch_mispred_i),
    .dmiss_i          (dmiss_i),
    .exc_valid_i      (exc_valid_i),
    .pc_en_o          (pc_en_o),
    .pc_sel_o         (pc_sel_o),
    .en_o             (en_o),
    .flush_o          (flush_o),
    .md_done_o        (md_done_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: remaining E-occupancy cycles of the mul/div op in flight
  // (0 = none) and the expected stall count
  int               md_left   = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  bit               cnt_known = 1'b0;
  logic             last_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic exc, input logic dm, input logic ms,
                      input logic br, input logic lu, input logic im);
    logic       e_pc_en;
    logic [1:0] e_sel;
    logic [3:0] e_en;
    logic [3:0] e_fl;
    logic       e_done;
    bit         low_prio;
    reset_i = rst; exc_valid_i = exc; dmiss_i = dm; md_start_i = ms;
    branch_mispred_i = br; load_use_i = lu; imiss_i = im;
    @(negedge clk_i);
    e_pc_en = 1'b1; e_sel = 2'd0; e_en = 4'b1111; e_fl = 4'b0000; e_done = 1'b0;
    low_prio = 1'b0;
    if (rst) begin
      e_pc_en = 1'b0; e_en = 4'b0000; e_fl = 4'b1111; md_left = 0;
    end else if (exc) begin
      e_fl = 4'b1111; e_sel = 2'd2; md_left = 0;
    end else if (dm) begin
      e_pc_en = 1'b0; e_en = 4'b1000; e_fl = 4'b1000;
    end else if (md_left > 1) begin
      e_pc_en = 1'b0; e_en = 4'b1100; e_fl = 4'b0100; md_left--;
    end else if (md_left == 1) begin
      e_done = 1'b1; md_left = 0; low_prio = 1'b1;
    end else if (ms) begin
      e_pc_en = 1'b0; e_en = 4'b1100; e_fl = 4'b0100; md_left = MD_LAT - 1;
    end else begin
      low_prio = 1'b1;
    end
    if (low_prio) begin
      if (br) begin
        e_sel = 2'd1; e_fl = 4'b0011;
      end else if (lu) begin
        e_pc_en = 1'b0; e_en = 4'b1110; e_fl = 4'b0010;
      end else if (im) begin
        e_pc_en = 1'b0; e_fl = 4'b0001;
      end
    end
    check("pc_en",   32'(pc_en_o),   32'(e_pc_en));
    check("pc_sel",  32'(pc_sel_o),  32'(e_sel));
    check("en",      32'(en_o),      32'(e_en));
    check("flush",   32'(flush_o),   32'(e_fl));
    check("md_done", 32'(md_done_o), 32'(e_done));
    if (cnt_known) check("stall_cnt", 32'(stall_cnt_o), 32'(model_cnt));
    last_done = md_done_o;
    if (rst) begin
      model_cnt = '0; cnt_known = 1'b1;
    end else if (!e_pc_en) begin
      model_cnt = model_cnt + 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    // reset for two cycles, then quiet
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("stall_cnt_after_reset", 32'(stall_cnt_o), 32'd0);

    // single load-use stall
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    check("stall_cnt_load_use", 32'(stall_cnt_o), 32'd1);

    // mul/div with md_start held: done on the MD_LAT-th cycle
    n = 1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (!last_done && n < 20) begin
      n++;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("md_latency", 32'(n), 32'(MD_LAT));
    idle();
    check("stall_cnt_md", 32'(stall_cnt_o), 32'd4);

    // mul/div with two dmiss cycles mid-op: done two cycles later
    n = 1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    while (!last_done && n < 20) begin
      n++;
      step(1'b0, 1'b0, (n == 3 || n == 4), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("md_latency_dmiss", 32'(n), 32'(MD_LAT + 2));
    idle();

    // branch beats load-use and imiss
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle();

    // exception on first MD_WAIT cycle, then back in RUN
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // exception in the would-be done cycle
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // reset mid-op aborts it
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();

    // long imiss run wraps the stall counter
    for (int i = 0; i < 260; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(999) == 0), ($urandom_range(15) == 0), ($urandom_range(5) == 0),
           ($urandom_range(4) == 0), ($urandom_range(7) == 0), ($urandom_range(4) == 0),
           ($urandom_range(4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and sequencing controller for the 5-stage in-order core. Drives the `en`/`flush` pair of every inter-stage pipeline register (F2D, D2E, E2M, M2W) plus the PC register enable and next-PC select. It resolves competing hazard sources by fixed priority and times multi-cycle mul/div ops with an internal down-counter. It also keeps a stall-cycle performance counter.

## Interface
- `MD_LAT`, 32: cycles a mul/div op occupies E, ≥2.
- `CNT_W`, 32: width of the stall performance counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous reset, active-high.
- `imiss` in 1: fetch has no valid instruction this cycle.
- `load_use` in 1: D depends on a load currently in E.
- `md_start` in 1: E holds a mul/div op.
- `branch_mispred` in 1: E resolved a mispredicted branch.
- `dmiss` in 1: M is waiting on data memory.
- `exc_valid` in 1: M raises an exception.
- `pc_en` out 1: PC register enable.
- `pc_sel` out 2: 0 = sequential, 1 = branch target, 2 = exception vector.
- `en` out 4: register enables; [0]=F2D, [1]=D2E, [2]=E2M, [3]=M2W.
- `flush` out 4: register flushes, same indexing.
- `md_done` out 1: mul/div result valid this cycle.
- `stall_cnt` out CNT_W: cycles in which `pc_en` was 0 outside reset.

## Operation
- States: RUN, MD_WAIT. Counter `md_cnt` is $clog2(MD_LAT) bits wide.
- All outputs are combinational from state and inputs. `stall_cnt` is registered.
- "Stall at stage X" means:
  - `pc_en`=0.
  - All registers upstream of X have `en`=0.
  - The register leaving X has `flush`=1, which inserts a bubble.
  - Downstream registers have `en`=1.
- Default output set: `pc_en`=1, `pc_sel`=0, `en`=4'b1111, `flush`=0.
- Priority, highest first. Only the highest active source acts.
  1. `exc_valid`: `flush`=4'b1111, `pc_en`=1, `pc_sel`=2. In MD_WAIT, also abort to RUN.
  2. `dmiss`: stall at M. `en`=4'b1000, `flush`=4'b1000.
  3. MD_WAIT with `md_cnt`≠0: stall at E. `en`=4'b1100, `flush`=4'b0100.
  4. `branch_mispred`: `pc_sel`=1, `pc_en`=1, `flush`=4'b0011. A simultaneous `load_use`/`imiss` is ignored.
  5. `load_use`: stall at D. `en`=4'b1110, `flush`=4'b0010.
  6. `imiss`: stall at F. `en`=4'b1111, `flush`=4'b0001.
- RUN to MD_WAIT: `md_start`=1 and no `exc_valid`/`dmiss` this cycle. This cycle is treated as priority 3, and `md_cnt` loads MD_LAT-2.
- In MD_WAIT:
  - `md_cnt` decrements each cycle not preempted by `exc_valid`/`dmiss`.
  - When `dmiss` is active, `md_cnt` holds.
  - When `md_cnt`=0: `md_done`=1, E is released (lower priorities 4–6 are evaluated normally), and the state returns to RUN.
- `md_start` is ignored in the cycle `md_done`=1, so the op is not re-launched.
- `stall_cnt`: increments when `pc_en`=0, wraps modulo 2^CNT_W.

## Timing
- During reset: `pc_en`=0, `en`=0, `flush`=4'b1111, `pc_sel`=0, `md_done`=0.
- State after reset: RUN, `md_cnt`=0, `stall_cnt`=0.
- Reset asserted mid-MD_WAIT aborts the op. RUN holds on the next cycle.
- Hazard response is zero-latency: outputs reflect inputs in the same cycle, and registers act on the next edge.
- Mul/div occupancy in E is exactly MD_LAT cycles, counting the `md_start` cycle and the `md_done` cycle, excluding `dmiss`-held cycles.
- An exception arriving in the same cycle as `md_done` wins: `md_done` is forced to 0.

## Structure
- Package `common` holds:
  - `pc_sel_t` enum (`PC_SEQ`, `PC_BR`, `PC_EXC`).
  - `pctrl_state_t` enum (`RUN`, `MD_WAIT`).
  - Stage index localparams `S_F2D`..`S_M2W`.
- One sub-module, `md_timer`: load/decrement/hold counter with a zero flag, parameterised by MD_LAT.
- The priority mux stays in `pipe_ctrl`.

## Test plan
- Reset held 2 cycles, then released with all inputs 0 → during reset `flush`=4'b1111, `en`=0; after release `en`=4'b1111, `pc_en`=1, `stall_cnt`=0.
- `load_use`=1 for 1 cycle → `en`=4'b1110, `flush`=4'b0010, `pc_en`=0; `stall_cnt`=1 afterwards.
- MD_LAT=4, `md_start` pulse held while stalled → 3 cycles with `en`=4'b1100, `flush`=4'b0100, then `md_done`=1 on the 4th cycle; `stall_cnt`=3.
- MD_WAIT with `dmiss`=1 for 2 cycles mid-op → `md_cnt` freezes; `md_done` arrives 2 cycles later than without `dmiss`.
- `branch_mispred`, `load_use` and `imiss` all =1 → `pc_sel`=1, `flush`=4'b0011, `pc_en`=1.
- `exc_valid`=1 during MD_WAIT with `md_cnt`=2 → `flush`=4'b1111, `pc_sel`=2, `md_done`=0; next cycle state is RUN.
